// File: rtl/grad_pkg.sv
// -----------------------------------------------------------------------------
// grad_pkg
// Shared constants for the gradient sum-of-squares block.
//   IN_WIDTH_DEF  : default signed width of one gradient component
//   OUT_WIDTH_DEF : default width of the sum-of-squares (square-root radical)
//   SAT_MAX       : largest radical representable at the default output width
//   cnt_width()   : counter width able to hold 0 .. depth-1 (never below 1)
// -----------------------------------------------------------------------------
package grad_pkg;

  localparam int IN_WIDTH_DEF  = 11;
  localparam int OUT_WIDTH_DEF = 21;

  // 2^OUT_WIDTH_DEF - 1
  localparam logic [OUT_WIDTH_DEF-1:0] SAT_MAX = {OUT_WIDTH_DEF{1'b1}};

  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/grad_abs_sq.sv
// -----------------------------------------------------------------------------
// grad_abs_sq
// Absolute value followed by square of one signed gradient component.
// Two register stages (S1 abs, S2 square), both advanced by en_i. Data
// registers carry no reset; the owning pipeline tracks validity.
// Ports:
//   clk_i  : clock, rising edge
//   en_i   : pipeline advance enable
//   g_i    : signed gradient component (two's complement)
//   sq_o   : unsigned square, registered at S2
// -----------------------------------------------------------------------------
module grad_abs_sq
  import grad_pkg::*;
#(
  parameter int IN_WIDTH = IN_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [IN_WIDTH-1:0]   g_i,
  output logic [2*IN_WIDTH-2:0] sq_o
);

  // (2^(IN_WIDTH-1))^2 needs 2*IN_WIDTH-1 bits, so the most-negative input
  // squares exactly instead of wrapping to zero.
  localparam int SQ_W = 2*IN_WIDTH - 1;

  // Result is unsigned IN_WIDTH bits, so -2^(IN_WIDTH-1) maps to 2^(IN_WIDTH-1).
  function automatic logic [IN_WIDTH-1:0] abs_fn(input logic signed [IN_WIDTH-1:0] v);
    logic [IN_WIDTH-1:0] u;
    u = v;
    return v[IN_WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  logic signed [IN_WIDTH-1:0] g_s;
  logic        [IN_WIDTH-1:0] abs_p1_d, abs_p1_q;
  logic        [SQ_W-1:0]     sq_p2_d,  sq_p2_q;

  assign g_s = g_i;

  always_comb begin
    abs_p1_d = abs_fn(g_s);
    sq_p2_d  = SQ_W'(abs_p1_q) * SQ_W'(abs_p1_q);
  end

  // ---- S1: absolute value ----
  always_ff @(posedge clk_i) begin
    if (en_i) abs_p1_q <= abs_p1_d;
  end

  // ---- S2: square ----
  always_ff @(posedge clk_i) begin
    if (en_i) sq_p2_q <= sq_p2_d;
  end

  assign sq_o = sq_p2_q;

endmodule

// File: rtl/grad_sqsum.sv
// -----------------------------------------------------------------------------
// grad_sqsum
// Three-stage valid/ready pipeline computing radical = gx*gx + gy*gy for a
// downstream square root, with last-pixel-of-line tagging.
//   S1 abs, S2 square (grad_abs_sq x2), S3 sum -> radical.
// The whole pipeline advances together on en = !m_valid || m_ready; bubbles
// are kept, and a stalled output holds radical/m_last/m_valid.
// Build option: GRAD_SQSUM_SAT_EN
//   defined   : S3 saturates to 2^OUT_WIDTH-1, ovf is a sticky overflow flag
//   undefined : S3 keeps the OUT_WIDTH LSBs, ovf is tied to 0
// Ports:
//   clk_main  : clock, rising edge
//   sys_rst_n : asynchronous active-low reset
//   s_valid / s_ready / gx / gy        : input beat (signed gradients)
//   m_valid / m_ready / radical / m_last : output beat
//   ovf       : overflow indication (see build option)
// -----------------------------------------------------------------------------
module grad_sqsum
  import grad_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int IMG_WIDTH = 640
) (
  input  logic                 clk_main,
  input  logic                 sys_rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [IN_WIDTH-1:0]  gx,
  input  logic [IN_WIDTH-1:0]  gy,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] radical,
  output logic                 m_last,
  output logic                 ovf
);

  localparam int SQ_W  = 2*IN_WIDTH - 1;
  // Sum width always keeps at least one bit above OUT_WIDTH so overflow is visible.
  localparam int SUM_W = (2*IN_WIDTH > OUT_WIDTH) ? 2*IN_WIDTH : OUT_WIDTH + 1;
  localparam int CNT_W = cnt_width(IMG_WIDTH);
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(IMG_WIDTH - 1);
  localparam logic [OUT_WIDTH-1:0] LIMIT   = {OUT_WIDTH{1'b1}};

`ifdef GRAD_SQSUM_SAT_EN
  function automatic logic over_fn(input logic [SUM_W-1:0] s);
    return s > SUM_W'(LIMIT);
  endfunction

  function automatic logic [OUT_WIDTH-1:0] sat_fn(input logic [SUM_W-1:0] s);
    return over_fn(s) ? LIMIT : s[OUT_WIDTH-1:0];
  endfunction
`else
  function automatic logic [OUT_WIDTH-1:0] sat_fn(input logic [SUM_W-1:0] s);
    return s[OUT_WIDTH-1:0];
  endfunction
`endif

  logic                 en;
  logic [SQ_W-1:0]      sq_x_p2, sq_y_p2;
  logic [SUM_W-1:0]     sum_p2;

  logic                 vld_p1_d, vld_p1_q;
  logic                 vld_p2_d, vld_p2_q;
  logic                 vld_p3_d, vld_p3_q;
  logic [OUT_WIDTH-1:0] radical_p3_d, radical_p3_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;

  assign en      = !vld_p3_q || m_ready;
  assign s_ready = en;

  // ---- S1/S2: abs and square, one instance per component ----
  grad_abs_sq #(.IN_WIDTH(IN_WIDTH)) u_abs_sq_x (
    .clk_i (clk_main),
    .en_i  (en),
    .g_i   (gx),
    .sq_o  (sq_x_p2)
  );

  grad_abs_sq #(.IN_WIDTH(IN_WIDTH)) u_abs_sq_y (
    .clk_i (clk_main),
    .en_i  (en),
    .g_i   (gy),
    .sq_o  (sq_y_p2)
  );

  assign sum_p2 = SUM_W'(sq_x_p2) + SUM_W'(sq_y_p2);

  always_comb begin
    vld_p1_d     = vld_p1_q;
    vld_p2_d     = vld_p2_q;
    vld_p3_d     = vld_p3_q;
    radical_p3_d = radical_p3_q;
    if (en) begin
      vld_p1_d     = s_valid;
      vld_p2_d     = vld_p1_q;
      vld_p3_d     = vld_p2_q;
      radical_p3_d = sat_fn(sum_p2);
    end
    // Column position of the beat currently presented; moves only on transfer.
    cnt_d = cnt_q;
    if (vld_p3_q && m_ready) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // ---- S3: sum register plus pipeline control ----
  always_ff @(posedge clk_main or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vld_p1_q     <= 1'b0;
      vld_p2_q     <= 1'b0;
      vld_p3_q     <= 1'b0;
      radical_p3_q <= '0;
      cnt_q        <= '0;
    end else begin
      vld_p1_q     <= vld_p1_d;
      vld_p2_q     <= vld_p2_d;
      vld_p3_q     <= vld_p3_d;
      radical_p3_q <= radical_p3_d;
      cnt_q        <= cnt_d;
    end
  end

`ifdef GRAD_SQSUM_SAT_EN
  logic ovf_d, ovf_q;

  // Only a real beat entering S3 can raise the flag; it then sticks.
  assign ovf_d = ovf_q | (en & vld_p2_q & over_fn(sum_p2));

  always_ff @(posedge clk_main or negedge sys_rst_n) begin
    if (!sys_rst_n) ovf_q <= 1'b0;
    else            ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_sum_hi;
  assign unused_sum_hi = ^sum_p2[SUM_W-1:OUT_WIDTH];
  assign ovf           = 1'b0;
`endif

  assign m_valid = vld_p3_q;
  assign radical = radical_p3_q;
  assign m_last  = vld_p3_q && (cnt_q == CNT_MAX);

endmodule
